// File: rtl/mult_result_buffer_pkg.sv
// Shared types for the multiplier result buffer: branch masks, branch tasks and the FU result packet.
// A packet whose decoded_vals is all zero is a bubble and carries no result.
package mult_result_buffer_pkg;

    localparam int BR_MASK_W = 4;

    typedef logic [BR_MASK_W-1:0] BR_MASK;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } BR_TASK;

    typedef struct packed {
        logic [31:0] result;
        logic [5:0]  dest_tag;
        BR_MASK      b_mask;
        logic [7:0]  decoded_vals;
    } FU_PACKET;

    function automatic logic br_hit(input BR_MASK mask, input BR_MASK id);
        return |(mask & id);
    endfunction

endpackage

// File: rtl/mult_result_buffer_br_entry_filter.sv
// Applies one branch resolution to one buffered packet: CLEAR drops the resolved bit,
// SQUASH kills the entry. Purely combinational, no backpressure.
module br_entry_filter
    import mult_result_buffer_pkg::*;
(
    input  FU_PACKET i_pack,
    input  logic     i_valid,
    input  BR_TASK   i_rem_br_task,
    input  BR_MASK   i_rem_b_id,
    output FU_PACKET o_pack,
    output logic     o_survive
);

    logic w_hit;

    assign w_hit = i_valid & br_hit(i_pack.b_mask, i_rem_b_id);

    always_comb begin
        o_pack = i_pack;
        if ((i_rem_br_task == CLEAR) && w_hit) begin
            o_pack.b_mask = i_pack.b_mask ^ i_rem_b_id;
        end
    end

    assign o_survive = i_valid & ~((i_rem_br_task == SQUASH) & w_hit);

endmodule

// File: rtl/mult_result_buffer.sv
// In-order collapsing queue between the multiplier and the CDB; 1-cycle minimum enqueue-to-request latency.
// Stalls the multiplier only when full and the head is not leaving this cycle.
`ifndef MULT_BUF_DEPTH
`define MULT_BUF_DEPTH 4
`endif

module mult_result_buffer
    import mult_result_buffer_pkg::*;
#(
    parameter  int DEPTH = `MULT_BUF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_ready,
    input  FU_PACKET         fu_pack,
    input  BR_TASK           rem_br_task,
    input  BR_MASK           rem_b_id,
    input  logic             cdb_gnt,
    output logic             cdb_req,
    output FU_PACKET         cdb_pack,
    output logic             stall,
    output logic [CNT_W-1:0] count
);

    FU_PACKET         r_entry [DEPTH];
    logic [CNT_W-1:0] r_count;

    FU_PACKET         w_filt [DEPTH];
    logic [DEPTH-1:0] w_surv;
    logic [DEPTH-1:0] w_keep;
    FU_PACKET         w_in_filt;
    logic             w_in_surv;
    logic             w_deq;
    logic             w_enq;
    logic [CNT_W-1:0] w_pos [DEPTH];
    logic [CNT_W-1:0] w_run;
    logic [CNT_W-1:0] w_keep_cnt;
    FU_PACKET         w_nxt [DEPTH];
    logic [CNT_W-1:0] w_nxt_count;

    for (genvar g = 0; g < DEPTH; g++) begin : g_filt
        br_entry_filter u_filt (
            .i_pack        (r_entry[g]),
            .i_valid       (CNT_W'(g) < r_count),
            .i_rem_br_task (rem_br_task),
            .i_rem_b_id    (rem_b_id),
            .o_pack        (w_filt[g]),
            .o_survive     (w_surv[g])
        );
    end

    br_entry_filter u_in_filt (
        .i_pack        (fu_pack),
        .i_valid       (w_enq),
        .i_rem_br_task (rem_br_task),
        .i_rem_b_id    (rem_b_id),
        .o_pack        (w_in_filt),
        .o_survive     (w_in_surv)
    );

    // Head is valid and not being squashed; a squashed head never reaches the CDB.
    assign cdb_req  = w_surv[0];
    assign cdb_pack = cdb_req ? w_filt[0] : '0;
    assign w_deq    = cdb_req & cdb_gnt;
    assign stall    = (r_count == CNT_W'(DEPTH)) & ~w_deq;
    assign w_enq    = data_ready & ~stall & (fu_pack.decoded_vals != '0);
    assign w_keep   = w_surv & ~{{(DEPTH-1){1'b0}}, w_deq};
    assign count    = r_count;

    always_comb begin
        w_run = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pos[i] = w_run;
            w_run    = w_run + CNT_W'(w_keep[i]);
        end
        w_keep_cnt = w_run;
    end

    // Survivor i lands at its prefix-count slot; an entry only ever moves toward the head.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            w_nxt[j] = '0;
        end
        for (int j = 0; j < DEPTH; j++) begin
            for (int i = j; i < DEPTH; i++) begin
                if (w_keep[i] && (w_pos[i] == CNT_W'(j))) begin
                    w_nxt[j] = w_filt[i];
                end
            end
            if (w_in_surv && (w_keep_cnt == CNT_W'(j))) begin
                w_nxt[j] = w_in_filt;
            end
        end
        w_nxt_count = w_keep_cnt + CNT_W'(w_in_surv);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            r_count <= w_nxt_count;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_nxt[i];
            end
        end
    end

endmodule
